// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, selector encodings,
// the datapath control bundle and its reset/NOP value.
package decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRAN   = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARII   = 7'b0010011;
  localparam logic [6:0] OP_ARIR   = 7'b0110011;
  localparam logic [6:0] OP_ARII32 = 7'b0011011;
  localparam logic [6:0] OP_ARIR32 = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_PRIV   = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic ASEL_REG  = 1'b0;
  localparam logic ASEL_PC   = 1'b1;
  localparam logic BSEL_REG  = 1'b0;
  localparam logic BSEL_IMM  = 1'b1;
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic [2:0] immsel;
    logic       regwen;
    logic       brun;
    logic       asel;
    logic       bsel;
    logic [3:0] alusel;
    logic       aluupper;
    logic       memrw;
    logic [1:0] memword;
    logic       memsign;
    logic [1:0] wbsel;
    logic       csrsel;
    logic       csr_wen;
    logic [1:0] csr_funct;
    logic       is_branch;
    logic       is_jump;
  } ctl_t;

  // Same shape as "addi x0,x0,0" but with every enable off.
  localparam ctl_t CTL_NOP = '{
    immsel:    IMM_I,
    regwen:    1'b0,
    brun:      1'b0,
    asel:      ASEL_REG,
    bsel:      BSEL_IMM,
    alusel:    ALU_ADD,
    aluupper:  1'b1,
    memrw:     MEM_READ,
    memword:   2'd0,
    memsign:   1'b0,
    wbsel:     WB_ALU,
    csrsel:    1'b0,
    csr_wen:   1'b0,
    csr_funct: 2'd0,
    is_branch: 1'b0,
    is_jump:   1'b0
  };

  // A trap bundle must have no architectural side effects.
  function automatic ctl_t trap_ctl(input ctl_t c);
    ctl_t t;
    t         = c;
    t.regwen  = 1'b0;
    t.memrw   = MEM_READ;
    t.csr_wen = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational decoder: opcode/funct fields -> ctl_t,
// plus illegal, uses_rs2 and fence flags. No state.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit CSR_EN = 1'b1
) (
  input  logic [6:0] i_op,
  input  logic [2:0] i_f3,
  input  logic       i_b30,
  input  logic       i_b13,
  output ctl_t       o_ctl,
  output logic       o_illegal,
  output logic       o_uses_rs2,
  output logic       o_is_fence
);

  localparam bit RV64 = (XLEN == 64);

  logic [3:0] w_alu_f3;
  logic [3:0] w_alu_r;
  logic [3:0] w_alu_i;

  assign w_alu_f3 = {1'b0, i_f3};
  assign w_alu_r  = {i_b30, i_f3};
  // Only shift-right immediates carry an op bit in inst[30].
  assign w_alu_i  = (i_f3 == 3'b101) ? w_alu_r : w_alu_f3;

  always_comb begin
    o_ctl      = CTL_NOP;
    o_illegal  = 1'b0;
    o_uses_rs2 = 1'b0;
    o_is_fence = 1'b0;
    unique case (1'b1)
      (i_op == OP_LUI): begin
        o_ctl.immsel = IMM_U;
        o_ctl.regwen = 1'b1;
        o_ctl.alusel = ALU_PASSB;
      end
      (i_op == OP_AUIPC): begin
        o_ctl.immsel = IMM_U;
        o_ctl.regwen = 1'b1;
        o_ctl.asel   = ASEL_PC;
      end
      (i_op == OP_JAL): begin
        o_ctl.immsel  = IMM_J;
        o_ctl.regwen  = 1'b1;
        o_ctl.asel    = ASEL_PC;
        o_ctl.wbsel   = WB_PC4;
        o_ctl.is_jump = 1'b1;
      end
      (i_op == OP_JALR): begin
        o_ctl.regwen  = 1'b1;
        o_ctl.wbsel   = WB_PC4;
        o_ctl.is_jump = 1'b1;
      end
      (i_op == OP_BRAN): begin
        o_ctl.immsel    = IMM_B;
        o_ctl.asel      = ASEL_PC;
        o_ctl.brun      = i_b13;
        o_ctl.is_branch = 1'b1;
        o_uses_rs2      = 1'b1;
      end
      (i_op == OP_LOAD): begin
        o_ctl.regwen  = 1'b1;
        o_ctl.wbsel   = WB_MEM;
        o_ctl.memword = i_f3[1:0];
        o_ctl.memsign = ~i_f3[2];
      end
      (i_op == OP_STORE): begin
        o_ctl.immsel  = IMM_S;
        o_ctl.memrw   = MEM_WRITE;
        o_ctl.memword = i_f3[1:0];
        o_uses_rs2    = 1'b1;
      end
      (i_op == OP_ARII): begin
        o_ctl.regwen = 1'b1;
        o_ctl.alusel = w_alu_i;
      end
      (i_op == OP_ARIR): begin
        o_ctl.regwen = 1'b1;
        o_ctl.bsel   = BSEL_REG;
        o_ctl.alusel = w_alu_r;
        o_uses_rs2   = 1'b1;
      end
      (i_op == OP_ARII32): begin
        o_ctl.regwen   = 1'b1;
        o_ctl.alusel   = w_alu_i;
        o_ctl.aluupper = 1'b0;
        o_illegal      = !RV64;
      end
      (i_op == OP_ARIR32): begin
        o_ctl.regwen   = 1'b1;
        o_ctl.bsel     = BSEL_REG;
        o_ctl.alusel   = w_alu_r;
        o_ctl.aluupper = 1'b0;
        o_uses_rs2     = 1'b1;
        o_illegal      = !RV64;
      end
      (i_op == OP_FENCE): begin
        o_is_fence = 1'b1;
      end
      (i_op == OP_PRIV): begin
        o_ctl.immsel    = IMM_Z;
        o_ctl.wbsel     = WB_CSR;
        o_ctl.regwen    = (i_f3 != 3'd0);
        o_ctl.csr_wen   = (i_f3[1:0] != 2'd0);
        o_ctl.csrsel    = i_f3[2];
        o_ctl.csr_funct = i_f3[1:0];
        o_illegal       = !CSR_EN;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
    // Compressed encodings are not supported here.
    if (i_op[1:0] != 2'b11) begin
      o_illegal  = 1'b1;
      o_is_fence = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: handshakes,
// load-use stall, flush, fence drain wait, illegal-inst trap hold.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit CSR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_load_vld,
  input  logic [4:0]      ex_load_rd,
  input  logic            mem_idle,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output ctl_t            out_ctl,
  output logic            out_trap
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FENCE_WAIT,
    S_TRAP_HOLD
  } state_t;

  state_t          r_state;
  logic            r_out_valid;
  logic            r_out_trap;
  logic [XLEN-1:0] r_out_pc;
  logic [31:0]     r_out_inst;
  ctl_t            r_out_ctl;

  ctl_t       w_ctl;
  logic       w_illegal;
  logic       w_uses_rs2;
  logic       w_is_fence;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_hazard;
  logic       w_drain;
  logic       w_in_ready;
  logic       w_accept;

  decode_comb #(
    .XLEN   (XLEN),
    .CSR_EN (CSR_EN)
  ) u_dec (
    .i_op       (in_inst[6:0]),
    .i_f3       (in_inst[14:12]),
    .i_b30      (in_inst[30]),
    .i_b13      (in_inst[13]),
    .o_ctl      (w_ctl),
    .o_illegal  (w_illegal),
    .o_uses_rs2 (w_uses_rs2),
    .o_is_fence (w_is_fence)
  );

  assign w_rs1 = in_inst[19:15];
  assign w_rs2 = in_inst[24:20];

  assign w_hazard = ex_load_vld
                 && (ex_load_rd != 5'd0)
                 && ((w_rs1 == ex_load_rd)
                  || (w_uses_rs2 && (w_rs2 == ex_load_rd)));

  assign w_drain    = !r_out_valid || out_ready;
  assign w_in_ready = (r_state == S_RUN) && w_drain
                   && !w_hazard && !flush;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_out_trap  <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= 32'h0000_0013;
      r_out_ctl   <= CTL_NOP;
    end else if (flush) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_out_trap  <= 1'b0;
    end else begin
      // A drained output with nothing accepted becomes a bubble.
      if (w_drain) begin
        r_out_valid <= w_accept;
        r_out_trap  <= w_accept && w_illegal;
        if (w_accept) begin
          r_out_pc   <= in_pc;
          r_out_inst <= in_inst;
          unique case (1'b1)
            w_illegal:  r_out_ctl <= trap_ctl(w_ctl);
            w_is_fence: r_out_ctl <= CTL_NOP;
            default:    r_out_ctl <= w_ctl;
          endcase
        end
      end
      unique case (r_state)
        S_RUN: begin
          if (w_accept && w_illegal)
            r_state <= S_TRAP_HOLD;
          else if (w_accept && w_is_fence)
            r_state <= S_FENCE_WAIT;
        end
        S_FENCE_WAIT: begin
          if (mem_idle)
            r_state <= S_RUN;
        end
        S_TRAP_HOLD: begin
          r_state <= S_TRAP_HOLD;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_trap  = r_out_trap;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;
  assign out_ctl   = r_out_ctl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode,
// hand sequences for stall, fence, trap, flush and reset.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic        ex_load_vld;
  logic [4:0]  ex_load_rd;
  logic        mem_idle;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  ctl_t        out_ctl;
  logic        out_trap;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_pc32;
  logic [31:0] out_inst32;
  ctl_t        out_ctl32;
  logic        out_trap32;

  int n_chk;
  int n_err;

  decode_stage #(.XLEN(64), .CSR_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .ex_load_vld (ex_load_vld),
    .ex_load_rd  (ex_load_rd),
    .mem_idle    (mem_idle),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_ctl     (out_ctl),
    .out_trap    (out_trap)
  );

  decode_stage #(.XLEN(32), .CSR_EN(1'b0)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready32),
    .in_inst     (in_inst),
    .in_pc       (in_pc[31:0]),
    .flush       (flush),
    .ex_load_vld (ex_load_vld),
    .ex_load_rd  (ex_load_rd),
    .mem_idle    (mem_idle),
    .out_valid   (out_valid32),
    .out_ready   (out_ready),
    .out_pc      (out_pc32),
    .out_inst    (out_inst32),
    .out_ctl     (out_ctl32),
    .out_trap    (out_trap32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    string       nm;
    logic        trap;
    logic        regwen;
    logic        memrw;
    logic        csr_wen;
    logic [3:0]  alusel;
    logic        bsel;
    logic        aluupper;
    logic [1:0]  wbsel;
    logic        brun;
    logic        br;
    logic        jmp;
    bit          full;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic [31:0] inst, input string nm,
    input logic trap, input logic regwen,
    input logic memrw, input logic csr_wen,
    input logic [3:0] alusel, input logic bsel,
    input logic aluupper, input logic [1:0] wbsel,
    input logic brun, input logic br,
    input logic jmp, input bit full);
    vec_t v;
    v.inst = inst;     v.nm = nm;
    v.trap = trap;     v.regwen = regwen;
    v.memrw = memrw;   v.csr_wen = csr_wen;
    v.alusel = alusel; v.bsel = bsel;
    v.aluupper = aluupper;
    v.wbsel = wbsel;   v.brun = brun;
    v.br = br;         v.jmp = jmp;
    v.full = full;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b0;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_inst = 32'h0;
    in_pc = 64'h0;
    flush = 1'b0;
    ex_load_vld = 1'b0;
    ex_load_rd = 5'd0;
    mem_idle = 1'b1;
    out_ready = 1'b1;

    // trap regw  mw   cw   alu  bsel upr  wb   brun br  jmp full
    vt.push_back(mk(32'h002081B3, "add",
      0, 1, 0, 0, 4'h0, 0, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h402081B3, "sub",
      0, 1, 0, 0, 4'h8, 0, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h002081BB, "addw",
      0, 1, 0, 0, 4'h0, 0, 0, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h40335293, "srai",
      0, 1, 0, 0, 4'hD, 1, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'hFFF00093, "addi_m1",
      0, 1, 0, 0, 4'h0, 1, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h00812203, "lw",
      0, 1, 0, 0, 4'h0, 1, 1, 2'd0, 0, 0, 0, 1));
    vt.push_back(mk(32'h00512223, "sw",
      0, 0, 1, 0, 4'h0, 1, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h00208463, "beq",
      0, 0, 0, 0, 4'h0, 1, 1, 2'd1, 0, 1, 0, 1));
    vt.push_back(mk(32'h0020E463, "bltu",
      0, 0, 0, 0, 4'h0, 1, 1, 2'd1, 1, 1, 0, 1));
    vt.push_back(mk(32'h010000EF, "jal",
      0, 1, 0, 0, 4'h0, 1, 1, 2'd2, 0, 0, 1, 1));
    vt.push_back(mk(32'h123452B7, "lui",
      0, 1, 0, 0, 4'hF, 1, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h300110F3, "csrrw",
      0, 1, 0, 1, 4'h0, 1, 1, 2'd3, 0, 0, 0, 1));
    vt.push_back(mk(32'h00000073, "ecall",
      0, 0, 0, 0, 4'h0, 1, 1, 2'd3, 0, 0, 0, 1));
    vt.push_back(mk(32'h0FF0000F, "fence",
      0, 0, 0, 0, 4'h0, 1, 1, 2'd1, 0, 0, 0, 1));
    vt.push_back(mk(32'h00000000, "zero",
      1, 0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0, 0));
    vt.push_back(mk(32'hFFFFFFFF, "ones",
      1, 0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0, 0));
    vt.push_back(mk(32'h002081B1, "lowbits",
      1, 0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0, 0));

    // reset values
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_trap", out_trap, 0);
    chk("rst_out_inst", out_inst, 32'h13);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_regwen", out_ctl.regwen, 0);
    chk("rst_memrw", out_ctl.memrw, 0);
    chk("rst_csr_wen", out_ctl.csr_wen, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // decode table
    for (int i = 0; i < vt.size(); i++) begin
      do_flush();
      in_valid = 1'b1;
      in_inst  = vt[i].inst;
      in_pc    = 64'h8000_0000_0000_0000 + 64'(i * 4);
      #1;
      chk({vt[i].nm, "_in_ready"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      chk({vt[i].nm, "_valid"}, out_valid, 1);
      chk({vt[i].nm, "_inst"}, out_inst, vt[i].inst);
      chk({vt[i].nm, "_pc"}, out_pc,
          64'h8000_0000_0000_0000 + 64'(i * 4));
      chk({vt[i].nm, "_trap"}, out_trap, vt[i].trap);
      chk({vt[i].nm, "_regwen"}, out_ctl.regwen, vt[i].regwen);
      chk({vt[i].nm, "_memrw"}, out_ctl.memrw, vt[i].memrw);
      chk({vt[i].nm, "_csr_wen"}, out_ctl.csr_wen, vt[i].csr_wen);
      if (vt[i].full) begin
        chk({vt[i].nm, "_alusel"}, out_ctl.alusel, vt[i].alusel);
        chk({vt[i].nm, "_bsel"}, out_ctl.bsel, vt[i].bsel);
        chk({vt[i].nm, "_aluupper"}, out_ctl.aluupper,
            vt[i].aluupper);
        chk({vt[i].nm, "_wbsel"}, out_ctl.wbsel, vt[i].wbsel);
        chk({vt[i].nm, "_brun"}, out_ctl.brun, vt[i].brun);
        chk({vt[i].nm, "_is_branch"}, out_ctl.is_branch, vt[i].br);
        chk({vt[i].nm, "_is_jump"}, out_ctl.is_jump, vt[i].jmp);
      end
    end

    // load-use hazard
    do_flush();
    in_valid = 1'b1;
    in_inst  = 32'h002081B3;
    step();
    chk("haz_pre_valid", out_valid, 1);
    in_inst     = 32'h00728333;
    ex_load_vld = 1'b1;
    ex_load_rd  = 5'd5;
    #1;
    chk("haz_rs1_ready", in_ready, 0);
    step();
    chk("haz_bubble", out_valid, 0);
    ex_load_vld = 1'b0;
    #1;
    chk("haz_clear_ready", in_ready, 1);
    step();
    chk("haz_acc_valid", out_valid, 1);
    chk("haz_acc_inst", out_inst, 32'h00728333);
    in_valid    = 1'b0;
    ex_load_vld = 1'b1;
    in_inst     = 32'h005383B3;
    #1;
    chk("haz_rs2_ready", in_ready, 0);
    in_inst = 32'h00538313;
    #1;
    chk("haz_imm_rs2_ready", in_ready, 1);
    ex_load_rd = 5'd0;
    in_inst    = 32'h000001B3;
    #1;
    chk("haz_x0_ready", in_ready, 1);
    ex_load_vld = 1'b0;

    // fence drain wait
    do_flush();
    mem_idle = 1'b0;
    in_valid = 1'b1;
    in_inst  = 32'h0FF0000F;
    step();
    chk("fence_valid", out_valid, 1);
    chk("fence_regwen", out_ctl.regwen, 0);
    chk("fence_trap", out_trap, 0);
    in_inst = 32'h002081B3;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fence_wait_ready", in_ready, 0);
      step();
    end
    chk("fence_drained", out_valid, 0);
    mem_idle = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      #1;
      if (in_ready) got = 1'b1;
      else step();
    end
    chk("fence_release", got, 1);
    step();
    chk("fence_next_valid", out_valid, 1);
    chk("fence_next_inst", out_inst, 32'h002081B3);

    // illegal trap hold
    do_flush();
    in_valid = 1'b1;
    in_inst  = 32'h0;
    step();
    chk("trap_valid", out_valid, 1);
    chk("trap_flag", out_trap, 1);
    chk("trap_regwen", out_ctl.regwen, 0);
    in_inst = 32'h002081B3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("trap_hold_ready", in_ready, 0);
      step();
    end
    flush = 1'b1;
    #1;
    chk("trap_flush_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("trap_flush_valid", out_valid, 0);
    chk("trap_flush_trap", out_trap, 0);
    #1;
    chk("trap_run_ready", in_ready, 1);
    step();
    chk("trap_run_valid", out_valid, 1);
    chk("trap_run_trap", out_trap, 0);

    // output stall then flush
    do_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00812203;
    in_pc     = 64'h1000;
    step();
    chk("stall_valid", out_valid, 1);
    in_inst = 32'h002081B3;
    in_pc   = 64'h2000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", in_ready, 0);
      chk("stall_inst", out_inst, 32'h00812203);
      chk("stall_pc", out_pc, 64'h1000);
      step();
    end
    chk("stall_still_valid", out_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    in_valid  = 1'b0;

    // XLEN and CSR_EN variants
    do_flush();
    in_valid = 1'b1;
    in_inst  = 32'h002081BB;
    step();
    chk("addw64_trap", out_trap, 0);
    chk("addw64_upper", out_ctl.aluupper, 0);
    chk("addw64_regwen", out_ctl.regwen, 1);
    chk("addw32_valid", out_valid32, 1);
    chk("addw32_trap", out_trap32, 1);
    chk("addw32_regwen", out_ctl32.regwen, 0);
    do_flush();
    in_valid = 1'b1;
    in_inst  = 32'h300110F3;
    step();
    chk("csr64_trap", out_trap, 0);
    chk("csr64_wen", out_ctl.csr_wen, 1);
    chk("csr32_trap", out_trap32, 1);
    chk("csr32_wen", out_ctl32.csr_wen, 0);

    // reset mid-operation
    do_flush();
    in_valid = 1'b1;
    in_inst  = 32'h002081B3;
    in_pc    = 64'h44;
    step();
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_inst", out_inst, 32'h13);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_regwen", out_ctl.regwen, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_post_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
